// File: rtl/tv80_wb_intercon.sv
// tv80_wb_intercon
// Wishbone interconnect placed directly behind the TV80 Wishbone master.
// Each CPU cycle is routed by its cycle tag to the memory slave (tags 00/10),
// the I/O slave (tag 01), or answered internally (tag 11, interrupt
// acknowledge, returns INT_VECTOR). A watchdog ends any slave cycle that is
// not acknowledged within TIMEOUT request cycles, returns 8'hFF, and records
// the failing address in a sticky error register.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wbs_*                   slave port facing the CPU (registered ack/data)
//   mem_*                   master port to the memory slave (+ M1 marker)
//   io_*                    master port to the I/O slave
//   err_o, err_adr_o        sticky watchdog flag and first failing address
//   err_clr_i               synchronous clear of err_o
module tv80_wb_intercon #(
    parameter int         TIMEOUT    = 255,
    parameter logic [7:0] INT_VECTOR = 8'hFF,
    parameter int         INTA_WAIT  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] wbs_adr_i,
    input  logic [1:0]  wbs_tga_i,
    input  logic [7:0]  wbs_dat_i,
    output logic [7:0]  wbs_dat_o,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic        wbs_ack_o,
    output logic [15:0] mem_adr_o,
    output logic [7:0]  mem_dat_o,
    input  logic [7:0]  mem_dat_i,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic        mem_m1_o,
    input  logic        mem_ack_i,
    output logic [15:0] io_adr_o,
    output logic [7:0]  io_dat_o,
    input  logic [7:0]  io_dat_i,
    output logic        io_cyc_o,
    output logic        io_stb_o,
    output logic        io_we_o,
    input  logic        io_ack_i,
    output logic        err_o,
    output logic [15:0] err_adr_o,
    input  logic        err_clr_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_INTA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Counter value in the last permitted request / INTA cycle.
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] INTA_LAST = 8'(INTA_WAIT);

    logic [1:0]  state_q, state_d;
    logic        sel_io_q, sel_io_d;
    logic        m1_q, m1_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  dat_o_q, dat_o_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] err_adr_q, err_adr_d;

    logic        slave_ack;
    logic        timeout;
    logic        req_active;

    assign req_active = (state_q == ST_REQ);
    // Only the selected slave's ack is honoured; the other is ignored.
    assign slave_ack  = sel_io_q ? io_ack_i : mem_ack_i;

    always_comb begin
        state_d   = state_q;
        sel_io_d  = sel_io_q;
        m1_d      = m1_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        dat_o_d   = dat_o_q;
        ack_d     = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    cnt_d    = 8'd0;
                    sel_io_d = (wbs_tga_i == 2'b01);
                    m1_d     = (wbs_tga_i == 2'b10);
                    state_d  = (wbs_tga_i == 2'b11) ? ST_INTA : ST_REQ;
                end
            end
            ST_REQ: begin
                // CPU abort beats both ack and timeout.
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (slave_ack) begin
                    // Ack wins over a coincident timeout.
                    rdata_d = sel_io_q ? io_dat_i : mem_dat_i;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    rdata_d = 8'hFF;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_INTA: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == INTA_LAST) begin
                    rdata_d = INT_VECTOR;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                ack_d   = 1'b1;
                dat_o_d = rdata_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error: a timeout always sets the flag even against a clear. The
    // address is only captured for the first failure, or when a clear and a
    // fresh timeout coincide (the new failure becomes the first one).
    always_comb begin
        err_d     = err_q;
        err_adr_d = err_adr_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
            if (!err_q || err_clr_i) begin
                err_adr_d = wbs_adr_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sel_io_q  <= 1'b0;
            m1_q      <= 1'b0;
            cnt_q     <= 8'd0;
            rdata_q   <= 8'h00;
            dat_o_q   <= 8'h00;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            err_adr_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            sel_io_q  <= sel_io_d;
            m1_q      <= m1_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            dat_o_q   <= dat_o_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
        end
    end

    // Strobes come straight from registered state, so reset drops them at once.
    assign mem_cyc_o = req_active && !sel_io_q;
    assign mem_stb_o = req_active && !sel_io_q;
    assign mem_m1_o  = req_active && !sel_io_q && m1_q;
    assign io_cyc_o  = req_active && sel_io_q;
    assign io_stb_o  = req_active && sel_io_q;

    assign mem_adr_o = wbs_adr_i;
    assign mem_dat_o = wbs_dat_i;
    assign mem_we_o  = wbs_we_i;
    assign io_adr_o  = wbs_adr_i;
    assign io_dat_o  = wbs_dat_i;
    assign io_we_o   = wbs_we_i;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign err_o     = err_q;
    assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_tv80_wb_intercon.sv
module tb_tv80_wb_intercon;

    localparam int         TO = 4;
    localparam logic [7:0] IV = 8'hE7;
    localparam int         IW = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] wbs_adr_i = '0;
    logic [1:0]  wbs_tga_i = '0;
    logic [7:0]  wbs_dat_i = '0;
    logic [7:0]  wbs_dat_o;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic        wbs_ack_o;
    logic [15:0] mem_adr_o, io_adr_o;
    logic [7:0]  mem_dat_o, io_dat_o;
    logic [7:0]  mem_dat_i = '0, io_dat_i = '0;
    logic        mem_cyc_o, mem_stb_o, mem_we_o, mem_m1_o;
    logic        io_cyc_o, io_stb_o, io_we_o;
    logic        mem_ack_i = 1'b0, io_ack_i = 1'b0;
    logic        err_o;
    logic [15:0] err_adr_o;
    logic        err_clr_i = 1'b0;

    int vectors = 0;
    int fails = 0;
    int txn_no = 0;

    // Reference error state.
    logic        err_m = 1'b0;
    logic [15:0] err_adr_m = 16'h0000;

    tv80_wb_intercon #(.TIMEOUT(TO), .INT_VECTOR(IV), .INTA_WAIT(IW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wbs_adr_i(wbs_adr_i), .wbs_tga_i(wbs_tga_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_we_i(wbs_we_i), .wbs_ack_o(wbs_ack_o),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
        .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
        .mem_m1_o(mem_m1_o), .mem_ack_i(mem_ack_i),
        .io_adr_o(io_adr_o), .io_dat_o(io_dat_o), .io_dat_i(io_dat_i),
        .io_cyc_o(io_cyc_o), .io_stb_o(io_stb_o), .io_we_o(io_we_o),
        .io_ack_i(io_ack_i),
        .err_o(err_o), .err_adr_o(err_adr_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One CPU transaction. Cycle c = 1 is the first cycle after the request
    // edge. ack_n: REQ cycle in which the slave acks (0 = never).
    // abort_at: cycle in which the CPU drops cyc (0 = none, no slave ack then).
    // clr_at: cycle in which err_clr_i is pulsed (only used with timeouts).
    task automatic run_txn(input logic [1:0] tag, input logic [15:0] adr,
                           input logic we, input logic [7:0] wdat,
                           input int ack_n, input logic [7:0] rdat,
                           input int abort_at, input int clr_at,
                           output int ack_cyc, output int stb_cnt,
                           output logic [7:0] got_dat);
        logic        is_inta, sel_io, tmo;
        int          n, ack_cycle, last;
        logic [7:0]  exp_dat;
        logic        err_after;
        logic [15:0] err_adr_after;
        logic        in_req, err_now;
        logic [15:0] err_adr_now;

        is_inta = (tag == 2'b11);
        sel_io  = (tag == 2'b01);
        tmo     = !is_inta && (abort_at == 0) && (ack_n == 0 || ack_n > TO);
        if (is_inta)      n = IW + 1;
        else if (tmo || ack_n == 0 || ack_n > TO) n = TO;
        else              n = ack_n;
        ack_cycle = n + 2;
        exp_dat   = is_inta ? IV : (tmo ? 8'hFF : rdat);
        err_after     = err_m;
        err_adr_after = err_adr_m;
        if (tmo) begin
            err_after = 1'b1;
            if (!err_m || clr_at == n) err_adr_after = adr;
        end
        last = (abort_at != 0) ? abort_at + 3 : ack_cycle + 1;
        ack_cyc = 0;
        stb_cnt = 0;
        got_dat = 8'h00;

        @(negedge clk);
        wbs_adr_i = adr; wbs_tga_i = tag; wbs_we_i = we; wbs_dat_i = wdat;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        mem_dat_i = sel_io ? 8'($urandom) : rdat;
        io_dat_i  = sel_io ? rdat : 8'($urandom);

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            in_req = !is_inta && (c <= n) && (abort_at == 0 || c <= abort_at);
            check("mem_stb", {mem_cyc_o, mem_stb_o}, {2{in_req && !sel_io}});
            check("io_stb",  {io_cyc_o, io_stb_o},   {2{in_req && sel_io}});
            check("m1",      mem_m1_o, in_req && tag == 2'b10);
            check("fwd", {mem_adr_o, io_adr_o, mem_dat_o, io_dat_o, mem_we_o, io_we_o},
                         {adr, adr, wdat, wdat, we, we});
            check("ack", wbs_ack_o, (abort_at == 0) && (c == ack_cycle));
            err_now     = (tmo && c > n) ? err_after : err_m;
            err_adr_now = (tmo && c > n) ? err_adr_after : err_adr_m;
            check("err", {err_o, err_adr_o}, {err_now, err_adr_now});
            if (mem_stb_o || io_stb_o) stb_cnt++;
            if (wbs_ack_o && ack_cyc == 0) begin
                ack_cyc = c;
                got_dat = wbs_dat_o;
            end
            if (abort_at == 0 && c == ack_cycle) begin
                check("rdata", wbs_dat_o, exp_dat);
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            if (c == abort_at) begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            // Selected slave acks in cycle ack_n; the other side sees noise.
            if (is_inta) begin
                mem_ack_i = 1'($urandom_range(0, 1));
                io_ack_i  = 1'($urandom_range(0, 1));
            end else if (sel_io) begin
                io_ack_i  = (abort_at == 0) && (c == ack_n);
                mem_ack_i = 1'($urandom_range(0, 1));
            end else begin
                mem_ack_i = (abort_at == 0) && (c == ack_n);
                io_ack_i  = 1'($urandom_range(0, 1));
            end
            err_clr_i = (c == clr_at);
        end
        mem_ack_i = 1'b0; io_ack_i = 1'b0; err_clr_i = 1'b0;
        err_m     = err_after;
        err_adr_m = err_adr_after;
        txn_no++;
        $display("txn %0d tag=%0d adr=%h we=%0b ack_n=%0d abort=%0d ack_cyc=%0d dat=%h err=%0b/%h",
                 txn_no, tag, adr, we, ack_n, abort_at, ack_cyc, got_dat, err_o, err_adr_o);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        err_m = 1'b0;
        check("err_clr", err_o, 1'b0);
        $display("txn %0d err_clr", ++txn_no);
    endtask

    initial begin
        int         ac, sc;
        logic [7:0] gd;
        logic [1:0] tg;
        int         an, ab;

        #1;
        check("rst_outs", {mem_cyc_o, mem_stb_o, io_cyc_o, io_stb_o, wbs_ack_o, wbs_dat_o, err_o, err_adr_o},
                          64'h0);
        @(negedge clk); @(negedge clk);
        rst_i = 1'b0;

        // Memory read, zero-wait.
        run_txn(2'b00, 16'h1234, 1'b0, 8'h00, 1, 8'hA5, 0, 0, ac, sc, gd);
        check("lit_mem_ack_cyc", ac, 3);
        check("lit_mem_dat", gd, 8'hA5);
        check("lit_mem_stb_cnt", sc, 1);
        // I/O write, three wait cycles.
        run_txn(2'b01, 16'h7F00, 1'b1, 8'h3C, 4, 8'h11, 0, 0, ac, sc, gd);
        check("lit_io_ack_cyc", ac, 6);
        check("lit_io_err", err_o, 1'b0);
        // Opcode fetch.
        run_txn(2'b10, 16'h0100, 1'b0, 8'h00, 2, 8'h3E, 0, 0, ac, sc, gd);
        check("lit_m1_dat", gd, 8'h3E);
        // Interrupt acknowledge.
        run_txn(2'b11, 16'h00FF, 1'b0, 8'h00, 0, 8'h00, 0, 0, ac, sc, gd);
        check("lit_inta_ack_cyc", ac, 5);
        check("lit_inta_dat", gd, 8'hE7);
        check("lit_inta_stb_cnt", sc, 0);
        // Timeout at BEEF, then a second one at 0001.
        run_txn(2'b00, 16'hBEEF, 1'b0, 8'h00, 0, 8'h77, 0, 0, ac, sc, gd);
        check("lit_to_ack_cyc", ac, 6);
        check("lit_to_dat", gd, 8'hFF);
        check("lit_to_stb_cnt", sc, 4);
        check("lit_to_err", {err_o, err_adr_o}, {1'b1, 16'hBEEF});
        run_txn(2'b00, 16'h0001, 1'b0, 8'h00, 0, 8'h77, 0, 0, ac, sc, gd);
        check("lit_to2_err_adr", err_adr_o, 16'hBEEF);
        clear_err();
        // Ack exactly in the TIMEOUT-th cycle.
        run_txn(2'b00, 16'h5555, 1'b0, 8'h00, TO, 8'h42, 0, 0, ac, sc, gd);
        check("lit_race_dat", gd, 8'h42);
        check("lit_race_err", err_o, 1'b0);
        // Clear coincident with a new timeout.
        run_txn(2'b01, 16'h1111, 1'b0, 8'h00, 0, 8'h00, 0, 0, ac, sc, gd);
        run_txn(2'b01, 16'h2222, 1'b0, 8'h00, 0, 8'h00, 0, TO, ac, sc, gd);
        check("lit_clr_race", {err_o, err_adr_o}, {1'b1, 16'h2222});
        // CPU abort mid-REQ.
        run_txn(2'b00, 16'h3333, 1'b0, 8'h00, 0, 8'h00, 2, 0, ac, sc, gd);
        check("lit_abort_ack", ac, 0);

        // Asynchronous reset in the middle of a request.
        @(negedge clk);
        wbs_adr_i = 16'h4444; wbs_tga_i = 2'b00; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        @(negedge clk);
        check("rst_pre_stb", mem_stb_o, 1'b1);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("rst_mid", {mem_cyc_o, mem_stb_o, io_cyc_o, io_stb_o, wbs_ack_o, wbs_dat_o, err_o, err_adr_o},
                         64'h0);
        err_m = 1'b0; err_adr_m = 16'h0000;
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; rst_i = 1'b0;
        run_txn(2'b00, 16'h4444, 1'b0, 8'h00, 1, 8'h5A, 0, 0, ac, sc, gd);
        check("lit_post_rst_ack", ac, 3);
        check("lit_post_rst_dat", gd, 8'h5A);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            tg = 2'($urandom);
            an = $urandom_range(0, TO + 1);
            ab = 0;
            if ($urandom_range(0, 7) == 0 && tg != 2'b11) begin
                an = 0;
                ab = $urandom_range(1, TO);
            end
            run_txn(tg, 16'($urandom), 1'($urandom), 8'($urandom), an, 8'($urandom), ab, 0, ac, sc, gd);
            if ($urandom_range(0, 9) == 0) clear_err();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/tv80_wb_intercon.md
# tv80_wb_intercon

Wishbone interconnect directly downstream of the TV80 Wishbone master. It decodes each CPU cycle by its cycle tag into a memory-slave cycle or an I/O-slave cycle, and answers interrupt-acknowledge cycles internally with a programmable vector. A bus watchdog terminates any slave cycle that is not acknowledged in time, returns 8'hFF to the CPU, and records the failing address.

## Interface
Parameters:
- TIMEOUT, 255: maximum REQ cycles without slave ack before forced termination (1..255; counter 8 bits).
- INT_VECTOR, 8'hFF: data returned on interrupt-acknowledge cycles.
- INTA_WAIT, 2: idle cycles in INTA before the vector is returned (0..15).

Ports:
- clk_i  in  1  system clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wbs_adr_i  in  16  CPU address.
- wbs_tga_i  in  2  cycle tag: 00 memory, 01 I/O, 10 opcode fetch (M1 memory), 11 interrupt acknowledge.
- wbs_dat_i  in  8  CPU write data.
- wbs_dat_o  out  8  read data to CPU (registered).
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  CPU cycle, strobe, write enable.
- wbs_ack_o  out  1  single-cycle ack to CPU (registered).
- mem_adr_o  out  16  memory-slave address (= wbs_adr_i).
- mem_dat_o  out  8  memory-slave write data (= wbs_dat_i).
- mem_dat_i  in  8  memory-slave read data.
- mem_cyc_o, mem_stb_o  out  1 each  memory-slave cycle/strobe.
- mem_we_o  out  1  = wbs_we_i.
- mem_m1_o  out  1  high while the selected memory cycle is tagged 10.
- mem_ack_i  in  1  memory-slave ack.
- io_adr_o, io_dat_o, io_dat_i, io_cyc_o, io_stb_o, io_we_o, io_ack_i: same roles as the mem_ ports for the I/O slave (no m1).
- err_o  out  1  sticky watchdog error flag.
- err_adr_o  out  16  address of the first timed-out cycle since the last clear.
- err_clr_i  in  1  synchronous clear of err_o.

## Operation
- States: IDLE, REQ, INTA, RESP.
- IDLE: when wbs_cyc_i & wbs_stb_i are sampled high, latch the tag-derived selection. Tag 00/10 selects mem; 01 selects io; 11 goes to INTA. Clear the counter.
- REQ: the selected slave's cyc/stb are held high by registered state. The other slave's cyc/stb stay low. Address, write data and we are forwarded combinationally from the CPU, which holds them stable.
  - On the selected ack: capture the slave data into rdata (for writes too), then go to RESP.
  - Otherwise the counter increments. The REQ cycle in which the count equals TIMEOUT-1 with no ack is a timeout. On a timeout: rdata = 8'hFF, go to RESP, set err_o. If err_o was clear, load err_adr_o with wbs_adr_i.
- INTA: wait INTA_WAIT cycles, then set rdata = INT_VECTOR and go to RESP. No slave strobe is asserted.
- RESP: wbs_ack_o = 1 and wbs_dat_o = rdata for exactly one cycle, then go to IDLE.
- Abort: if wbs_cyc_i is low in REQ or INTA, go to IDLE next edge, with no ack and no error.
- Ack and timeout in the same cycle: ack wins, no error.
- err_clr_i and a new timeout in the same cycle: the flag stays set, and err_adr_o loads the new address.
- Ack on the non-selected slave is ignored.

## Timing
- Reset: state IDLE. All cyc/stb/ack outputs 0, wbs_dat_o 8'h00, rdata 8'h00, err_o 0, err_adr_o 16'h0000, counter 0. Asynchronous: slave strobes drop immediately, even mid-cycle.
- Zero-wait slave (ack combinational in the first REQ cycle): wbs_ack_o goes high 2 cycles after the edge that samples the CPU strobe.
- Slave ack in the n-th REQ cycle (n = 1 for the first): wbs_ack_o high n+1 cycles after the request edge.
- Timeout: exactly TIMEOUT REQ cycles, then one RESP cycle.
- INTA: wbs_ack_o high INTA_WAIT+2 cycles after the request edge.
- Slave strobe drops on the edge that samples the slave ack; slaves must not depend on a stretched strobe.
- A strobe still high in the IDLE cycle after RESP starts a new cycle (back-to-back allowed).

## Test plan
- Memory read, tag 00, adr 16'h1234, mem acks in the first REQ cycle with 8'hA5: mem_stb_o high 1 cycle, io_stb_o never high, wbs_ack_o at request+2 with wbs_dat_o = 8'hA5.
- I/O write, tag 01, adr 16'h7F00, data 8'h3C, io acks after 3 wait cycles: io_we_o = 1 and io_dat_o = 8'h3C throughout, wbs_ack_o at request+5, err_o stays 0.
- Opcode fetch, tag 10: mem_m1_o high during REQ. INTA, tag 11, INT_VECTOR = 8'hE7, INTA_WAIT = 2: no slave strobe, wbs_ack_o at request+4 with 8'hE7.
- Memory slave never acks, adr 16'hBEEF, TIMEOUT = 4: mem_stb_o high 4 cycles, wbs_ack_o with 8'hFF, err_o = 1, err_adr_o = 16'hBEEF. A second timeout at 16'h0001 leaves err_adr_o unchanged. err_clr_i clears err_o.
- Boundary races: ack exactly on the TIMEOUT-th cycle returns slave data and no error; err_clr_i coincident with a timeout leaves err_o = 1; wbs_cyc_i dropped mid-REQ produces no ack.
- rst_i asserted mid-REQ: mem_stb_o falls before the next edge, all outputs take their reset values, and the next request completes normally.
